// File: rtl/system_0_sysid_pkg.sv
// Shared types and constants for the system ID checker.
package system_0_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_LAT_ID,
    ST_RD_TS,
    ST_LAT_TS,
    ST_FIN
  } sysid_chk_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEF_ID = 32'd0;
  localparam logic [31:0] SYSID_DEF_TS = 32'd1563511986;

endpackage

// File: rtl/system_0_avm_single_read.sv
// Single Avalon-MM read engine: waitrequest handshake, fixed read latency and
// a saturating stall counter that aborts the read after TIMEOUT_CYCLES stalls.
module system_0_avm_single_read
  import system_0_sysid_pkg::*;
#(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  logic        address,
  output logic        avm_read,
  output logic        avm_address,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        timed_out
);

  localparam int SW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [1:0] LAT_LAST = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam bit HAS_LAT = (READ_LATENCY > 0);
  localparam bit HAS_TO  = (TIMEOUT_CYCLES > 0);

  logic          read_q;
  logic          addr_q;
  logic          lat_q;
  logic [1:0]    lat_cnt_q, lat_cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          accept;

  assign accept      = read_q && !avm_waitrequest;
  assign rvalid      = HAS_LAT ? (lat_q && (lat_cnt_q == LAT_LAST)) : accept;
  assign timed_out   = HAS_TO && read_q && avm_waitrequest && (stall_q == STALL_LAST);
  assign rdata       = avm_readdata;
  assign avm_read    = read_q;
  assign avm_address = addr_q;

  always_comb begin
    stall_d   = stall_q;
    lat_cnt_d = lat_cnt_q;
    // Stall counter saturates rather than wrapping back into range.
    if (go) begin
      stall_d = '0;
    end else if (read_q && avm_waitrequest && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
    if (go || accept) begin
      lat_cnt_d = '0;
    end else if (lat_q) begin
      lat_cnt_d = lat_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_q    <= 1'b0;
      addr_q    <= SYSID_ADDR_ID;
      lat_q     <= 1'b0;
      lat_cnt_q <= '0;
      stall_q   <= '0;
    end else begin
      stall_q   <= stall_d;
      lat_cnt_q <= lat_cnt_d;
      if (go) begin
        read_q <= 1'b1;
        addr_q <= address;
        lat_q  <= 1'b0;
      end else if (accept) begin
        read_q <= 1'b0;
        lat_q  <= HAS_LAT;
      end else if (timed_out) begin
        read_q <= 1'b0;
      end else if (lat_q && (lat_cnt_q == LAT_LAST)) begin
        lat_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/system_0_sysid_checker.sv
// Reads the sysid ID and timestamp words after reset or on request and
// reports whether both match the expected build constants.
module system_0_sysid_checker
  import system_0_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEF_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEF_TS,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_chk_state_t state_q;
  logic             auto_q;
  logic             launch;
  logic             go;
  logic             go_addr;
  logic [31:0]      rdata;
  logic             rvalid;
  logic             timed_out;

  assign launch  = (state_q == ST_IDLE) && (start || auto_q);
  assign go      = launch || (rvalid && ((state_q == ST_RD_ID) || (state_q == ST_LAT_ID)));
  assign go_addr = launch ? SYSID_ADDR_ID : SYSID_ADDR_TS;

  system_0_avm_single_read #(
    .READ_LATENCY   (READ_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_read (
    .clock           (clock),
    .reset           (reset),
    .go              (go),
    .address         (go_addr),
    .avm_read        (avm_read),
    .avm_address     (avm_address),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .rdata           (rdata),
    .rvalid          (rvalid),
    .timed_out       (timed_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      auto_q   <= AUTO_START;
      busy     <= 1'b0;
      done     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      done   <= 1'b0;
      auto_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (launch) begin
            state_q  <= ST_RD_ID;
            busy     <= 1'b1;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
          end
        end
        ST_RD_ID, ST_LAT_ID: begin
          if (timed_out) begin
            state_q <= ST_FIN;
            timeout <= 1'b1;
            done    <= 1'b1;
          end else if (rvalid) begin
            state_q  <= ST_RD_TS;
            id_value <= rdata;
          end else if ((state_q == ST_RD_ID) && !avm_waitrequest) begin
            state_q <= ST_LAT_ID;
          end
        end
        ST_RD_TS, ST_LAT_TS: begin
          // Flags are only set on a clean finish, so a timeout leaves both at 0.
          if (timed_out) begin
            state_q <= ST_FIN;
            timeout <= 1'b1;
            done    <= 1'b1;
          end else if (rvalid) begin
            state_q  <= ST_FIN;
            ts_value <= rdata;
            id_ok    <= (id_value == EXPECTED_ID);
            ts_ok    <= (rdata == EXPECTED_TIMESTAMP);
            done     <= 1'b1;
          end else if ((state_q == ST_RD_TS) && !avm_waitrequest) begin
            state_q <= ST_LAT_TS;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_system_0_sysid_checker.sv
// Directed bench: instance A uses default parameters; instance B uses
// two-cycle read latency, a 4-cycle timeout and a non-zero expected ID.
module tb_system_0_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1563511986;
  localparam logic [31:0] ID_B    = 32'h0000_5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: zero latency, combinational slave data.
  logic        a_rst, a_start, a_wait, a_read, a_addr, a_busy, a_done;
  logic        a_idok, a_tsok, a_to;
  logic [31:0] a_rdata, a_idv, a_tsv, a_mem_ts;
  int          a_acc = 0;
  int          a_dn  = 0;

  assign a_rdata = (a_read && !a_wait) ? (a_addr ? a_mem_ts : 32'd0) : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (a_read && !a_wait) a_acc <= a_acc + 1;
    if (a_done) a_dn <= a_dn + 1;
  end

  system_0_sysid_checker dut_a (
    .clock           (clk),
    .reset           (a_rst),
    .start           (a_start),
    .avm_address     (a_addr),
    .avm_read        (a_read),
    .avm_waitrequest (a_wait),
    .avm_readdata    (a_rdata),
    .busy            (a_busy),
    .done            (a_done),
    .id_ok           (a_idok),
    .ts_ok           (a_tsok),
    .timeout         (a_to),
    .id_value        (a_idv),
    .ts_value        (a_tsv)
  );

  // Instance B: slave data appears two cycles after the accept cycle.
  logic        b_rst, b_start, b_wait, b_read, b_addr, b_busy, b_done;
  logic        b_idok, b_tsok, b_to;
  logic [31:0] b_rdata, b_idv, b_tsv, b_p1, b_p2;

  always @(posedge clk) begin
    b_p1 <= (b_read && !b_wait) ? (b_addr ? TS_GOOD : ID_B) : 32'hDEADBEEF;
    b_p2 <= b_p1;
  end
  assign b_rdata = b_p2;

  system_0_sysid_checker #(
    .EXPECTED_ID    (ID_B),
    .READ_LATENCY   (2),
    .TIMEOUT_CYCLES (4),
    .AUTO_START     (1'b1)
  ) dut_b (
    .clock           (clk),
    .reset           (b_rst),
    .start           (b_start),
    .avm_address     (b_addr),
    .avm_read        (b_read),
    .avm_waitrequest (b_wait),
    .avm_readdata    (b_rdata),
    .busy            (b_busy),
    .done            (b_done),
    .id_ok           (b_idok),
    .ts_ok           (b_tsok),
    .timeout         (b_to),
    .id_value        (b_idv),
    .ts_value        (b_tsv)
  );

  initial begin
    int acc0, dn0;
    a_rst = 1'b1; a_start = 1'b0; a_wait = 1'b0; a_mem_ts = TS_GOOD;
    b_rst = 1'b1; b_start = 1'b0; b_wait = 1'b0;
    repeat (3) tick();

    chk("a_reset_flags", 32'({a_read, a_addr, a_busy, a_done, a_idok, a_tsok, a_to}), 32'd0);
    chk("a_reset_idv", a_idv, 32'd0);
    chk("a_reset_tsv", a_tsv, 32'd0);
    chk("b_reset_flags", 32'({b_read, b_addr, b_busy, b_done, b_idok, b_tsok, b_to}), 32'd0);

    // Auto-start: cycle 0 is the first cycle with reset low.
    a_rst = 1'b0; b_rst = 1'b0;
    tick();
    chk("a_auto_c1", 32'({a_read, a_addr, a_busy, a_done}), 32'b1010);
    tick();
    chk("a_auto_c2", 32'({a_read, a_addr, a_busy, a_done}), 32'b1110);
    tick();
    chk("a_auto_c3", 32'({a_read, a_busy, a_done, a_idok, a_tsok, a_to}), 32'b011110);
    chk("a_auto_tsv", a_tsv, TS_GOOD);
    a_start = 1'b1;  // start during the done cycle must be ignored
    tick();
    a_start = 1'b0;
    chk("a_fin_start_ignored", 32'({a_read, a_busy, a_done, a_idok}), 32'b0001);

    // Back-to-back launch in the cycle after done, with a bad timestamp.
    a_mem_ts = TS_GOOD - 32'd1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("a_relaunch_clear", 32'({a_read, a_busy, a_idok, a_tsok}), 32'b1100);
    chk("a_relaunch_tsv", a_tsv, 32'd0);
    tick();
    tick();
    chk("a_mismatch_flags", 32'({a_done, a_idok, a_tsok, a_to}), 32'b1100);
    chk("a_mismatch_tsv", a_tsv, 32'd1563511985);
    tick();

    // Start pulses in cycles 0 and 2: one check, two reads.
    a_mem_ts = TS_GOOD;
    acc0 = a_acc; dn0 = a_dn;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (6) tick();
    chk("a_busy_start_dones", a_dn - dn0, 32'd1);
    chk("a_busy_start_reads", a_acc - acc0, 32'd2);
    chk("a_busy_start_tsok", 32'({a_busy, a_tsok}), 32'b01);

    // B's auto-check finished long ago.
    chk("b_auto_flags", 32'({b_busy, b_idok, b_tsok, b_to}), 32'b0110);
    chk("b_auto_idv", b_idv, ID_B);

    // Latency 2 with three stall cycles on the ID read: done at cycle 10.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_wait = 1'b1;
    chk("b_stall_c1", 32'({b_read, b_addr}), 32'b10);
    tick();
    chk("b_stall_c2", 32'({b_read, b_addr}), 32'b10);
    tick();
    chk("b_stall_c3", 32'({b_read, b_addr}), 32'b10);
    tick();
    b_wait = 1'b0;
    chk("b_stall_c4", 32'({b_read, b_addr}), 32'b10);
    repeat (5) tick();
    chk("b_stall_c9_done", 32'(b_done), 32'd0);
    tick();
    chk("b_stall_c10", 32'({b_done, b_idok, b_tsok, b_to}), 32'b1110);
    chk("b_stall_tsv", b_tsv, TS_GOOD);
    tick();

    // Waitrequest stuck: read high for exactly 4 cycles then abort.
    b_wait = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (3) tick();
    chk("b_to_c4_read", 32'(b_read), 32'd1);
    tick();
    chk("b_to_c5", 32'({b_read, b_done, b_to, b_idok, b_tsok}), 32'b01100);
    b_wait = 1'b0;
    tick();
    chk("b_to_hold", 32'({b_busy, b_to}), 32'b01);

    // Reset during LAT_TS, then the auto-start check runs again.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (4) tick();
    chk("b_rst_lat_ts", 32'({b_read, b_busy}), 32'b01);
    b_rst = 1'b1;
    tick();
    chk("b_rst_flags", 32'({b_read, b_addr, b_busy, b_done, b_idok, b_tsok, b_to}), 32'd0);
    chk("b_rst_idv", b_idv, 32'd0);
    b_rst = 1'b0;
    repeat (6) tick();
    chk("b_rst_c6_done", 32'(b_done), 32'd0);
    tick();
    chk("b_rst_auto_pass", 32'({b_done, b_idok, b_tsok, b_to}), 32'b1110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
